// File: rtl/data_beat_scheduler_pkg.sv
// Shared types and widths for the data-beat layer sequencer.
// State encoding, frame dimension width, group width, flush gap floor.
package data_beat_scheduler_pkg;

  localparam int DIM_W   = 9;
  localparam int GRP_W   = 8;
  localparam int GAP_MIN = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/data_beat_scheduler_frame_len_calc.sv
// Two-stage frame length calculator: col*row, pooled length, overflow.
// Ports: clk, rst, ld (capture cfg), col, row, stride_sel -> conv_len, pool_len, ovf.
module frame_len_calc
  import data_beat_scheduler_pkg::*;
#(
  parameter int ADDR_BIT = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld,
  input  logic [DIM_W-1:0]    col,
  input  logic [DIM_W-1:0]    row,
  input  logic                stride_sel,
  output logic [ADDR_BIT-1:0] conv_len,
  output logic [ADDR_BIT-1:0] pool_len,
  output logic                ovf
);

  localparam logic [17:0] PROD_MAX =
    18'((1 << ADDR_BIT) - 1);

  logic [17:0]         prod_d, prod_q;
  logic [15:0]         pprod_d, pprod_q;
  logic                sel_d, sel_q;
  logic                ld2_d, ld2_q;
  logic [ADDR_BIT-1:0] conv_len_d, conv_len_q;
  logic [ADDR_BIT-1:0] pool_len_d, pool_len_q;
  logic                ovf_d, ovf_q;

  always_comb begin
    prod_d     = prod_q;
    pprod_d    = pprod_q;
    sel_d      = sel_q;
    conv_len_d = conv_len_q;
    pool_len_d = pool_len_q;
    ovf_d      = ovf_q;
    ld2_d      = ld;
    // stage 1: multiply straight from the cfg inputs on the accept cycle
    if (ld) begin
      prod_d  = 18'(col) * 18'(row);
      pprod_d = 16'(col >> 1) * 16'(row >> 1);
      sel_d   = stride_sel;
    end
    // stage 2: select pooled length, compare full product
    if (ld2_q) begin
      conv_len_d = ADDR_BIT'(prod_q);
      pool_len_d = sel_q ? ADDR_BIT'(prod_q)
                         : ADDR_BIT'(pprod_q);
      ovf_d      = prod_q > PROD_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      pprod_q    <= '0;
      sel_q      <= 1'b0;
      ld2_q      <= 1'b0;
      conv_len_q <= '0;
      pool_len_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      pprod_q    <= pprod_d;
      sel_q      <= sel_d;
      ld2_q      <= ld2_d;
      conv_len_q <= conv_len_d;
      pool_len_q <= pool_len_d;
      ovf_q      <= ovf_d;
    end
  end

  assign conv_len = conv_len_q;
  assign pool_len = pool_len_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/data_beat_scheduler.sv
// Layer sequencer: walks oc groups / ic passes, drives weight load and shutdown.
// Ports: start/abort/cfg_* in, wt_ack/quant_done/pool_done events; all outputs registered.
module data_beat_scheduler
  import data_beat_scheduler_pkg::*;
#(
  parameter int ADDR_BIT = 12,
  parameter int GRP_BIT  = GRP_W,
  parameter int GAP      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DIM_W-1:0]    cfg_col,
  input  logic [DIM_W-1:0]    cfg_row,
  input  logic                cfg_pool_stride_sel,
  input  logic [GRP_BIT-1:0]  cfg_ic_grps,
  input  logic [GRP_BIT-1:0]  cfg_oc_grps,
  input  logic                wt_ack,
  input  logic                quant_done,
  input  logic                pool_done,
  output logic                shutdown,
  output logic [DIM_W-1:0]    conv_col,
  output logic [DIM_W-1:0]    conv_row,
  output logic                pool_stride_sel,
  output logic [ADDR_BIT-1:0] conv_addr_len,
  output logic [ADDR_BIT-1:0] pool_addr_len,
  output logic                wt_req,
  output logic [GRP_BIT-1:0]  ic_idx,
  output logic [GRP_BIT-1:0]  oc_idx,
  output logic                first_pass,
  output logic                last_pass,
  output logic                busy,
  output logic                layer_done,
  output logic                cfg_err
);

  localparam int GAP_EFF = (GAP < GAP_MIN) ? GAP_MIN : GAP;
  localparam int GW      = $clog2(GAP_EFF);
  localparam logic [GW-1:0]      GAP_LAST = GW'(GAP_EFF - 1);
  localparam logic [GRP_BIT-1:0] ONE      = GRP_BIT'(1);

  state_e               state_d, state_q;
  logic [DIM_W-1:0]     col_d, col_q;
  logic [DIM_W-1:0]     row_d, row_q;
  logic                 stride_d, stride_q;
  logic [GRP_BIT-1:0]   ic_grps_d, ic_grps_q;
  logic [GRP_BIT-1:0]   oc_grps_d, oc_grps_q;
  logic [GRP_BIT-1:0]   ic_idx_d, ic_idx_q;
  logic [GRP_BIT-1:0]   oc_idx_d, oc_idx_q;
  logic                 calc_cnt_d, calc_cnt_q;
  logic [GW-1:0]        gap_cnt_d, gap_cnt_q;
  logic                 shutdown_d, shutdown_q;
  logic                 wt_req_d, wt_req_q;
  logic                 busy_d, busy_q;
  logic                 layer_done_d, layer_done_q;
  logic                 cfg_err_d, cfg_err_q;
  logic                 first_d, first_q;
  logic                 last_d, last_q;
  logic                 accept;
  logic                 run_evt;
  logic                 ovf;

  assign accept  = (state_q == S_IDLE) && start && !abort;
  // the last pass of a group ends on pool output, the others on quant output
  assign run_evt = last_q ? pool_done : quant_done;

  frame_len_calc #(
    .ADDR_BIT (ADDR_BIT)
  ) u_len (
    .clk        (clk),
    .rst        (rst),
    .ld         (accept),
    .col        (cfg_col),
    .row        (cfg_row),
    .stride_sel (cfg_pool_stride_sel),
    .conv_len   (conv_addr_len),
    .pool_len   (pool_addr_len),
    .ovf        (ovf)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    stride_d   = stride_q;
    ic_grps_d  = ic_grps_q;
    oc_grps_d  = oc_grps_q;
    ic_idx_d   = ic_idx_q;
    oc_idx_d   = oc_idx_q;
    calc_cnt_d = calc_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    cfg_err_d  = cfg_err_q;
    first_d    = first_q;
    last_d     = last_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            col_d      = cfg_col;
            row_d      = cfg_row;
            stride_d   = cfg_pool_stride_sel;
            ic_grps_d  = (cfg_ic_grps == '0) ? ONE
                                             : cfg_ic_grps;
            oc_grps_d  = (cfg_oc_grps == '0) ? ONE
                                             : cfg_oc_grps;
            ic_idx_d   = '0;
            oc_idx_d   = '0;
            cfg_err_d  = 1'b0;
            calc_cnt_d = 1'b0;
            state_d    = S_CALC;
          end
        end
        S_CALC: begin
          if (!calc_cnt_q) begin
            calc_cnt_d = 1'b1;
          end else if (ovf) begin
            cfg_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (wt_ack) begin
            gap_cnt_d = '0;
            state_d   = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = S_RUN;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        S_RUN: begin
          if (run_evt) begin
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (ic_idx_q < ic_grps_q - ONE) begin
            ic_idx_d = ic_idx_q + ONE;
            state_d  = S_LOAD;
          end else if (oc_idx_q < oc_grps_q - ONE) begin
            ic_idx_d = '0;
            oc_idx_d = oc_idx_q + ONE;
            state_d  = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // pass flags only move on LOAD entry, so they hold through RUN
    if (state_d == S_LOAD && state_q != S_LOAD) begin
      first_d = (ic_idx_d == '0);
      last_d  = (ic_idx_d == ic_grps_d - ONE);
    end

    shutdown_d   = (state_d != S_RUN);
    wt_req_d     = (state_d == S_LOAD);
    busy_d       = (state_d != S_IDLE);
    layer_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      stride_q     <= 1'b0;
      ic_grps_q    <= '0;
      oc_grps_q    <= '0;
      ic_idx_q     <= '0;
      oc_idx_q     <= '0;
      calc_cnt_q   <= 1'b0;
      gap_cnt_q    <= '0;
      shutdown_q   <= 1'b1;
      wt_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      stride_q     <= stride_d;
      ic_grps_q    <= ic_grps_d;
      oc_grps_q    <= oc_grps_d;
      ic_idx_q     <= ic_idx_d;
      oc_idx_q     <= oc_idx_d;
      calc_cnt_q   <= calc_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shutdown_q   <= shutdown_d;
      wt_req_q     <= wt_req_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
      cfg_err_q    <= cfg_err_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

  assign shutdown        = shutdown_q;
  assign conv_col        = col_q;
  assign conv_row        = row_q;
  assign pool_stride_sel = stride_q;
  assign wt_req          = wt_req_q;
  assign ic_idx          = ic_idx_q;
  assign oc_idx          = oc_idx_q;
  assign first_pass      = first_q;
  assign last_pass       = last_q;
  assign busy            = busy_q;
  assign layer_done      = layer_done_q;
  assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_data_beat_scheduler.sv
// Scoreboard bench for data_beat_scheduler.
// Stimulus pushes expected handshakes/layer ends; a negedge monitor pops and checks.
module tb_data_beat_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [8:0]  cfg_col, cfg_row;
  logic        cfg_pool_stride_sel;
  logic [7:0]  cfg_ic_grps, cfg_oc_grps;
  logic        wt_ack, quant_done, pool_done;
  logic        shutdown;
  logic [8:0]  conv_col, conv_row;
  logic        pool_stride_sel;
  logic [11:0] conv_addr_len, pool_addr_len;
  logic        wt_req;
  logic [7:0]  ic_idx, oc_idx;
  logic        first_pass, last_pass;
  logic        busy, layer_done, cfg_err;

  data_beat_scheduler #(
    .ADDR_BIT (12),
    .GRP_BIT  (8),
    .GAP      (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .cfg_col             (cfg_col),
    .cfg_row             (cfg_row),
    .cfg_pool_stride_sel (cfg_pool_stride_sel),
    .cfg_ic_grps         (cfg_ic_grps),
    .cfg_oc_grps         (cfg_oc_grps),
    .wt_ack              (wt_ack),
    .quant_done          (quant_done),
    .pool_done           (pool_done),
    .shutdown            (shutdown),
    .conv_col            (conv_col),
    .conv_row            (conv_row),
    .pool_stride_sel     (pool_stride_sel),
    .conv_addr_len       (conv_addr_len),
    .pool_addr_len       (pool_addr_len),
    .wt_req              (wt_req),
    .ic_idx              (ic_idx),
    .oc_idx              (oc_idx),
    .first_pass          (first_pass),
    .last_pass           (last_pass),
    .busy                (busy),
    .layer_done          (layer_done),
    .cfg_err             (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int ic;
    int oc;
    bit fp;
    bit lp;
    bit err;
    bit chk_len;
    int clen;
    int plen;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   hs_cnt = 0;
  int   ld_cnt = 0;

  task automatic check(input string nm, input int act,
                       input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hs(input int ic, input int oc,
                         input bit fp, input bit lp);
    exp_t x;
    x = '{0, ic, oc, fp, lp, 0, 0, 0, 0};
    sbq.push_back(x);
  endtask

  task automatic push_done(input bit err, input bit cl,
                           input int clen, input int plen);
    exp_t x;
    x = '{1, 0, 0, 0, 0, err, cl, clen, plen};
    sbq.push_back(x);
  endtask

  // monitor: one pop per handshake or layer_done
  always @(negedge clk) begin
    if (!rst) begin
      if (wt_req && wt_ack) begin
        hs_cnt++;
        if (sbq.size() == 0) begin
          check("hs_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("hs_order", 0, int'(e.is_done));
          check("hs_ic_idx", int'(ic_idx), e.ic);
          check("hs_oc_idx", int'(oc_idx), e.oc);
          check("hs_first", int'(first_pass), int'(e.fp));
          check("hs_last", int'(last_pass), int'(e.lp));
        end
      end
      if (layer_done) begin
        ld_cnt++;
        if (sbq.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("done_order", 1, int'(e.is_done));
          check("done_cfg_err", int'(cfg_err), int'(e.err));
          if (e.chk_len) begin
            check("done_conv_len", int'(conv_addr_len), e.clen);
            check("done_pool_len", int'(pool_addr_len), e.plen);
          end
        end
      end
    end
  end

  task automatic start_layer(input int col, input int row,
                             input bit s, input int ic,
                             input int oc);
    cfg_col             = 9'(col);
    cfg_row             = 9'(row);
    cfg_pool_stride_sel = s;
    cfg_ic_grps         = 8'(ic);
    cfg_oc_grps         = 8'(oc);
    start               = 1'b1;
    tick();
    start               = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!wt_req && n < 50) begin
      tick();
      n++;
    end
    check("wait_wt_req", int'(wt_req), 1);
  endtask

  // one full pass; gap = cycles shutdown stays high after the ack
  task automatic do_pass(input int ack_dly, input bit last,
                         input bit fin, output int gap);
    wait_req();
    repeat (ack_dly) tick();
    wt_ack = 1'b1;
    tick();
    wt_ack = 1'b0;
    gap = 0;
    while (shutdown && gap < 50) begin
      gap++;
      tick();
    end
    if (!last) begin
      pool_done = 1'b1;
      tick();
      pool_done = 1'b0;
      check("pool_ignored", int'(shutdown), 0);
      quant_done = 1'b1;
      tick();
      quant_done = 1'b0;
      check("quant_advance", int'(shutdown), 1);
    end else begin
      quant_done = 1'b1;
      tick();
      quant_done = 1'b0;
      check("quant_ignored", int'(shutdown), 0);
      pool_done = 1'b1;
      tick();
      check("pool_advance", int'(shutdown), 1);
      check("ld_early", int'(layer_done), 0);
      tick();
      check("ld_timing", int'(layer_done), int'(fin));
      tick();
      pool_done = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gap;
    int hs0;
    int ld0;
    int nreq;
    int got;
    rst = 1'b1;
    start = 0; abort = 0; wt_ack = 0;
    quant_done = 0; pool_done = 0;
    cfg_col = '0; cfg_row = '0; cfg_pool_stride_sel = 0;
    cfg_ic_grps = '0; cfg_oc_grps = '0;
    #12;
    check("rst_shutdown", int'(shutdown), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_wt_req", int'(wt_req), 0);
    check("rst_layer_done", int'(layer_done), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_conv_len", int'(conv_addr_len), 0);
    check("rst_first", int'(first_pass), 0);
    check("rst_last", int'(last_pass), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single pass, stride 1, ack in 3rd LOAD cycle
    push_hs(0, 0, 1, 1);
    push_done(0, 1, 80, 80);
    ld0 = ld_cnt;
    start_layer(10, 8, 1, 1, 1);
    check("busy_after_start", int'(busy), 1);
    do_pass(2, 1, 1, gap);
    check("t1_gap", gap, 4);
    check("t1_conv_col", int'(conv_col), 10);
    check("t1_conv_row", int'(conv_row), 8);
    tick();
    check("t1_ld_once", ld_cnt - ld0, 1);
    check("t1_idle", int'(busy), 0);

    // stride 2, ic=3 oc=2
    push_hs(0, 0, 1, 0);
    push_hs(1, 0, 0, 0);
    push_hs(2, 0, 0, 1);
    push_hs(0, 1, 1, 0);
    push_hs(1, 1, 0, 0);
    push_hs(2, 1, 0, 1);
    push_done(0, 1, 80, 20);
    hs0 = hs_cnt;
    ld0 = ld_cnt;
    start_layer(10, 8, 0, 3, 2);
    for (int oc = 0; oc < 2; oc++) begin
      for (int ic = 0; ic < 3; ic++) begin
        do_pass(0, ic == 2, (ic == 2) && (oc == 1), gap);
        check("t2_gap", gap, 4);
      end
    end
    tick();
    check("t2_hs_count", hs_cnt - hs0, 6);
    check("t2_ld_once", ld_cnt - ld0, 1);
    check("t2_ic_final", int'(ic_idx), 2);
    check("t2_oc_final", int'(oc_idx), 1);

    // overflow: 100*50 = 5000
    push_done(1, 0, 0, 0);
    start_layer(100, 50, 1, 1, 1);
    nreq = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (wt_req) nreq++;
      if (layer_done) begin
        got = 1;
        break;
      end
      tick();
    end
    check("ovf_no_wt_req", nreq, 0);
    check("ovf_layer_done", got, 1);
    tick();
    check("ovf_idle", int'(busy), 0);
    check("ovf_err_sticky", int'(cfg_err), 1);
    push_hs(0, 0, 1, 1);
    push_done(0, 1, 16, 4);
    start_layer(4, 4, 0, 1, 1);
    check("err_cleared", int'(cfg_err), 0);
    do_pass(1, 1, 1, gap);
    check("t3_gap", gap, 4);
    tick();

    // abort and start together: abort wins
    abort = 1'b1;
    start_layer(7, 7, 1, 1, 1);
    abort = 1'b0;
    check("abort_start_busy", int'(busy), 0);
    check("abort_start_col", int'(conv_col), 4);

    // abort mid-RUN with ic=2
    push_hs(0, 0, 1, 0);
    start_layer(10, 8, 1, 2, 1);
    wait_req();
    wt_ack = 1'b1;
    tick();
    wt_ack = 1'b0;
    gap = 0;
    while (shutdown && gap < 50) begin
      gap++;
      tick();
    end
    check("t4_gap", gap, 4);
    start_layer(3, 3, 0, 1, 1);
    check("busy_start_col", int'(conv_col), 10);
    check("busy_start_run", int'(shutdown), 0);
    ld0 = ld_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_shutdown", int'(shutdown), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_wt_req", int'(wt_req), 0);
    repeat (4) tick();
    check("abort_no_ld", ld_cnt - ld0, 0);
    push_hs(0, 0, 1, 1);
    push_done(0, 1, 36, 9);
    start_layer(6, 6, 0, 1, 1);
    do_pass(0, 1, 1, gap);
    check("t4b_gap", gap, 4);
    tick();

    // async reset mid-FLUSH
    push_hs(0, 0, 1, 1);
    start_layer(10, 8, 1, 1, 1);
    wait_req();
    wt_ack = 1'b1;
    tick();
    wt_ack = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_shutdown", int'(shutdown), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_wt_req", int'(wt_req), 0);
    check("arst_conv_len", int'(conv_addr_len), 0);
    check("arst_conv_col", int'(conv_col), 0);
    check("arst_first", int'(first_pass), 0);
    check("arst_ic_idx", int'(ic_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check("arst_idle_busy", int'(busy), 0);
    check("arst_idle_shutdown", int'(shutdown), 1);

    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
